// File: rtl/sevenseg_pkg.sv
// Shared constants, state encoding and segment decode for the seven-segment display driver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sevenseg_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int BIN_W      = 14;
    localparam int BCD_W      = 16;

    localparam logic [BIN_W-1:0] MAX_VAL    = 14'd9999;
    // Final value of the iteration counter: 14 shift steps, counted 0..13
    localparam logic [3:0]       LAST_ITER  = 4'd13;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_t;

    // BCD digit to segment pattern; codes 10-15 never occur and show nothing
    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] pat;
        case (digit)
            4'd0:    pat = SEG_0;
            4'd1:    pat = SEG_1;
            4'd2:    pat = SEG_2;
            4'd3:    pat = SEG_3;
            4'd4:    pat = SEG_4;
            4'd5:    pat = SEG_5;
            4'd6:    pat = SEG_6;
            4'd7:    pat = SEG_7;
            4'd8:    pat = SEG_8;
            4'd9:    pat = SEG_9;
            default: pat = SEG_BLANK;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: saturates a 14-bit binary value to 9999 and converts it to 4 BCD digits.
// Latency: free-running, 16 cycles per conversion (IDLE 1, SHIFT 14, DONE 1); bcd valid while bcd_valid=1.
// Backpressure: none; bin is sampled only in IDLE and the result is offered for the single DONE cycle.
module bin2bcd_seq
    import sevenseg_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [BIN_W-1:0] bin,
    output logic [BCD_W-1:0] bcd,
    output logic             bcd_valid,
    output logic             busy
);

    conv_state_t      state;
    logic [BCD_W-1:0] acc;
    logic [BCD_W-1:0] acc_adj;
    logic [BIN_W-1:0] bin_sh;
    logic [3:0]       iter;

    // The accumulator is a flop and stays stable through DONE, so the consumer copies it directly
    assign bcd       = acc;
    assign bcd_valid = (state == DONE);

    // Add-3 correction of every BCD nibble that would overflow past 9 when doubled
    always_comb begin
        acc_adj = acc;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (acc[4*i +: 4] >= 4'd5) begin
                acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
            end
        end
    end

    // Converter FSM: capture, 14 adjust-and-shift steps, hand off result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            acc    <= '0;
            bin_sh <= '0;
            iter   <= '0;
            busy   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bin_sh <= (bin > MAX_VAL) ? MAX_VAL : bin;
                    acc    <= '0;
                    iter   <= '0;
                    busy   <= 1'b1;
                    state  <= SHIFT;
                end
                SHIFT: begin
                    {acc, bin_sh} <= {acc_adj, bin_sh} << 1;
                    iter          <= iter + 4'd1;
                    if (iter == LAST_ITER) begin
                        busy  <= 1'b0;
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/sevenseg_driver.sv
// Four-digit common-anode display driver: converts value to BCD and scans one digit per refresh strobe edge.
// Latency: new value visible within 32 clk cycles; digit outputs change on the clk edge that sees the strobe rise.
// Backpressure: none; the strobe is sampled as data and outputs hold between strobe edges.
module sevenseg_driver
    import sevenseg_pkg::*;
#(
    parameter bit BLANK_LEADING = 1'b1,
    parameter int DP_DIGIT      = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             scan_clk,
    input  logic [BIN_W-1:0] value,
    input  logic             dp_en,
    output logic [3:0]       an,
    output logic [6:0]       seg,
    output logic             dp_n,
    output logic             busy
);

    localparam logic [1:0] DP_IDX = DP_DIGIT[1:0];

    logic                             scan_q;
    logic                             tick;
    logic [1:0]                       digit_idx;
    logic [1:0]                       next_idx;
    logic [NUM_DIGITS-1:0][3:0]       disp;
    logic                             disp_valid;
    logic [BCD_W-1:0]                 conv_bcd;
    logic                             conv_valid;
    logic                             upper_zero;
    logic                             blank_sel;
    logic [6:0]                       nxt_seg;
    logic [3:0]                       nxt_an;
    logic                             nxt_dp_n;

    bin2bcd_seq u_conv (
        .clk       (clk),
        .rst       (rst),
        .bin       (value),
        .bcd       (conv_bcd),
        .bcd_valid (conv_valid),
        .busy      (busy)
    );

    assign tick     = scan_clk & ~scan_q;
    assign next_idx = digit_idx + 2'd1;

    // Display registers only change on a finished conversion, so no digit shows a partial result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp       <= '0;
            disp_valid <= 1'b0;
        end else if (conv_valid) begin
            disp       <= conv_bcd;
            disp_valid <= 1'b1;
        end
    end

    // Pattern for the digit about to be selected, with leading-zero blanking above digit 0
    always_comb begin
        upper_zero = 1'b1;
        blank_sel  = 1'b0;
        for (int j = NUM_DIGITS - 1; j >= 1; j--) begin
            if (disp[j] != 4'd0) begin
                upper_zero = 1'b0;
            end
            if (2'(j) == next_idx) begin
                blank_sel = BLANK_LEADING && upper_zero;
            end
        end
        nxt_seg  = (!disp_valid || blank_sel) ? SEG_BLANK : seg_decode(disp[next_idx]);
        nxt_an   = disp_valid ? ~(4'b0001 << next_idx) : 4'b1111;
        nxt_dp_n = ~(dp_en && (next_idx == DP_IDX));
    end

    // Strobe edge detect and scan outputs, advanced one digit per strobe rise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_q    <= 1'b0;
            digit_idx <= 2'd0;
            an        <= 4'b1111;
            seg       <= SEG_BLANK;
            dp_n      <= 1'b1;
        end else begin
            scan_q <= scan_clk;
            if (tick) begin
                digit_idx <= next_idx;
                an        <= nxt_an;
                seg       <= nxt_seg;
                dp_n      <= nxt_dp_n;
            end
        end
    end

endmodule
